// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared state type, frame field positions and key constants for the IR command path
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    HOLD
  } ir_state_t;

  localparam int INV_MSB = 31;
  localparam int INV_LSB = 24;
  localparam int KEY_MSB = 23;
  localparam int KEY_LSB = 16;
  localparam int CUS_MSB = 15;
  localparam int CUS_LSB = 0;

  localparam logic [7:0] MUTE_KEY_DEF = 8'h0C;

endpackage

// File: rtl/ir_hold_timer.sv
// rtl/ir_hold_timer.sv - loadable down-counter with zero flag that times the held-key window
module ir_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load wins over decrement; the count parks at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ir_cmd_ctrl.sv
// rtl/ir_cmd_ctrl.sv - turns decoded IR frames into handshaked key commands with repeat, mute and error tracking
module ir_cmd_ctrl
  import ir_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         HOLD_MS   = 150,
  parameter bit         REPEAT_EN = 1'b1,
  parameter logic [7:0] MUTE_KEY  = MUTE_KEY_DEF
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iDATA_READY,
  input  logic [31:0] iDATA,
  output logic        oCMD_VALID,
  input  logic        iCMD_READY,
  output logic [7:0]  oCMD,
  output logic        oCMD_REPEAT,
  output logic        oMUTE,
  output logic [7:0]  oERR_CNT,
  output logic        oOVERFLOW
);

  localparam int RELOAD = HOLD_MS * (CLK_HZ / 1000) - 1;
  localparam int TW     = $clog2(RELOAD) + 1;
  localparam logic [TW-1:0] RELOAD_V = TW'(RELOAD);

  ir_state_t  state_q, state_d;
  logic       dr_q;
  logic [7:0] last_q, last_d;
  logic       valid_d, rep_d, mute_d, ovf_d;
  logic [7:0] cmd_d, err_d;
  logic       tmr_load, tmr_zero;

  logic       frame_ev, frame_ok, frame_vld;
  logic [7:0] key;
  logic       unused_custom;

  assign key           = iDATA[KEY_MSB:KEY_LSB];
  assign frame_ev      = iDATA_READY && !dr_q;
  assign frame_ok      = (iDATA[INV_MSB:INV_LSB] == ~key);
  assign frame_vld     = frame_ev && frame_ok;
  assign unused_custom = ^iDATA[CUS_MSB:CUS_LSB];

  ir_hold_timer #(.W(TW)) u_hold_timer (
    .clk      (iCLK),
    .rst_n    (iRST_n),
    .load     (tmr_load),
    .load_val (RELOAD_V),
    .dec      (state_q == HOLD),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = oCMD_VALID;
    cmd_d    = oCMD;
    rep_d    = oCMD_REPEAT;
    mute_d   = oMUTE;
    err_d    = oERR_CNT;
    ovf_d    = oOVERFLOW;
    last_d   = last_q;
    tmr_load = 1'b0;

    if (frame_ev && !frame_ok && (oERR_CNT != 8'hFF)) begin
      err_d = oERR_CNT + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_vld) begin
          state_d = OFFER;
          valid_d = 1'b1;
          cmd_d   = key;
          rep_d   = 1'b0;
          last_d  = key;
        end
      end
      OFFER: begin
        // a frame arriving while a command is pending is lost, even in the handshake cycle
        if (frame_vld) begin
          ovf_d = 1'b1;
        end
        if (oCMD_VALID && iCMD_READY) begin
          state_d  = HOLD;
          valid_d  = 1'b0;
          tmr_load = 1'b1;
          if ((oCMD == MUTE_KEY) && !oCMD_REPEAT) begin
            mute_d = !oMUTE;
          end
        end
      end
      HOLD: begin
        if (frame_vld) begin
          if (key == last_q) begin
            tmr_load = 1'b1;
            if (REPEAT_EN) begin
              state_d = OFFER;
              valid_d = 1'b1;
              cmd_d   = key;
              rep_d   = 1'b1;
            end
          end else begin
            state_d = OFFER;
            valid_d = 1'b1;
            cmd_d   = key;
            rep_d   = 1'b0;
            last_d  = key;
          end
        end else if (tmr_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // the edge register tracks the level even in reset, so a level already high at release is no edge
  always_ff @(posedge iCLK) begin
    dr_q <= iDATA_READY;
    if (!iRST_n) begin
      state_q     <= IDLE;
      oCMD_VALID  <= 1'b0;
      oCMD        <= 8'h00;
      oCMD_REPEAT <= 1'b0;
      oMUTE       <= 1'b0;
      oERR_CNT    <= 8'h00;
      oOVERFLOW   <= 1'b0;
      last_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      oCMD_VALID  <= valid_d;
      oCMD        <= cmd_d;
      oCMD_REPEAT <= rep_d;
      oMUTE       <= mute_d;
      oERR_CNT    <= err_d;
      oOVERFLOW   <= ovf_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// tb/tb_ir_cmd_ctrl.sv - randomized and directed bench for ir_cmd_ctrl, repeat-enabled and repeat-disabled instances
module tb_ir_cmd_ctrl;

  localparam int WIN = 10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        dr    = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] data  = 32'h0;

  logic       o_valid [2];
  logic [7:0] o_cmd   [2];
  logic       o_rep   [2];
  logic       o_mute  [2];
  logic [7:0] o_err   [2];
  logic       o_ovf   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ir_cmd_ctrl #(.CLK_HZ(1000), .HOLD_MS(10), .REPEAT_EN(1'b1), .MUTE_KEY(8'h0C)) u_rep (
    .iCLK(clk), .iRST_n(rst_n), .iDATA_READY(dr), .iDATA(data),
    .oCMD_VALID(o_valid[0]), .iCMD_READY(ready), .oCMD(o_cmd[0]), .oCMD_REPEAT(o_rep[0]),
    .oMUTE(o_mute[0]), .oERR_CNT(o_err[0]), .oOVERFLOW(o_ovf[0])
  );

  ir_cmd_ctrl #(.CLK_HZ(1000), .HOLD_MS(10), .REPEAT_EN(1'b0), .MUTE_KEY(8'h0C)) u_norep (
    .iCLK(clk), .iRST_n(rst_n), .iDATA_READY(dr), .iDATA(data),
    .oCMD_VALID(o_valid[1]), .iCMD_READY(ready), .oCMD(o_cmd[1]), .oCMD_REPEAT(o_rep[1]),
    .oMUTE(o_mute[1]), .oERR_CNT(o_err[1]), .oOVERFLOW(o_ovf[1])
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", nm, idx, $time, act, exp);
    end
  endtask

  // Reference: pending command, key of last accepted command, and the edge at which the hold window opened.
  bit         m_pend [2];
  bit         m_rep  [2];
  bit         m_mute [2];
  bit         m_ovf  [2];
  bit         m_has  [2];
  logic [7:0] m_cmd  [2];
  logic [7:0] m_err  [2];
  logic [7:0] m_last [2];
  int         m_anchor [2];
  bit         m_prev = 1'b0;
  int         n = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_rep[i] = 0; m_mute[i] = 0; m_ovf[i] = 0; m_has[i] = 0;
      m_cmd[i] = 8'h0; m_err[i] = 8'h0; m_last[i] = 8'h0; m_anchor[i] = 0;
    end
  end

  task automatic model_step();
    bit         ev, ok, was_pend;
    logic [7:0] k;
    n++;
    ev     = dr && !m_prev;
    m_prev = dr;
    k      = data[23:16];
    ok     = (data[31:24] == 8'(~data[23:16]));
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pend[i] = 0; m_rep[i] = 0; m_mute[i] = 0; m_ovf[i] = 0; m_has[i] = 0;
        m_cmd[i] = 8'h0; m_err[i] = 8'h0; m_last[i] = 8'h0;
        continue;
      end
      was_pend = m_pend[i];
      if (ev && !ok) begin
        if (m_err[i] != 8'hFF) m_err[i] = m_err[i] + 8'd1;
      end else if (ev && was_pend) begin
        m_ovf[i] = 1;
      end else if (ev) begin
        if (m_has[i] && (n - m_anchor[i] <= WIN) && (k == m_last[i])) begin
          m_anchor[i] = n;
          if (i == 0) begin
            m_pend[i] = 1; m_cmd[i] = k; m_rep[i] = 1;
          end
        end else begin
          m_pend[i] = 1; m_cmd[i] = k; m_rep[i] = 0; m_last[i] = k;
        end
      end
      if (was_pend && ready) begin
        m_pend[i]   = 0;
        m_has[i]    = 1;
        m_anchor[i] = n;
        if ((m_cmd[i] == 8'h0C) && !m_rep[i]) m_mute[i] = !m_mute[i];
      end
    end
  endtask

  // Compare after every edge, then predict the next edge from the inputs now stable.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("valid", i, 32'(o_valid[i]), 32'(m_pend[i]));
      chk("cmd",   i, 32'(o_cmd[i]),   32'(m_cmd[i]));
      chk("rep",   i, 32'(o_rep[i]),   32'(m_rep[i]));
      chk("mute",  i, 32'(o_mute[i]),  32'(m_mute[i]));
      chk("err",   i, 32'(o_err[i]),   32'(m_err[i]));
      chk("ovf",   i, 32'(o_ovf[i]),   32'(m_ovf[i]));
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int c);
    repeat (c) tick();
  endtask

  task automatic rise(input logic [31:0] d);
    data = d;
    dr   = 1'b1;
    tick();
  endtask

  task automatic fall();
    dr = 1'b0;
    tick();
  endtask

  task automatic lit_all_zero(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_valid"}, i, 32'(o_valid[i]), 32'h0);
      chk({nm, "_cmd"},   i, 32'(o_cmd[i]),   32'h0);
      chk({nm, "_rep"},   i, 32'(o_rep[i]),   32'h0);
      chk({nm, "_mute"},  i, 32'(o_mute[i]),  32'h0);
      chk({nm, "_err"},   i, 32'(o_err[i]),   32'h0);
      chk({nm, "_ovf"},   i, 32'(o_ovf[i]),   32'h0);
    end
  endtask

  initial begin
    logic [7:0] keys [3];
    logic [7:0] k;
    keys[0] = 8'h01; keys[1] = 8'h02; keys[2] = 8'h0C;

    idle(3);
    lit_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // first command, accepted in its first offered cycle
    ready = 1'b1;
    rise(32'hFE01_1234);
    for (int i = 0; i < 2; i++) begin
      chk("first_valid", i, 32'(o_valid[i]), 32'h1);
      chk("first_cmd",   i, 32'(o_cmd[i]),   32'h01);
      chk("first_rep",   i, 32'(o_rep[i]),   32'h0);
    end
    fall();
    for (int i = 0; i < 2; i++) chk("first_done", i, 32'(o_valid[i]), 32'h0);

    // same key 5 cycles after the handshake
    idle(4);
    rise(32'hFE01_1234);
    chk("rpt5_valid", 0, 32'(o_valid[0]), 32'h1);
    chk("rpt5_rep",   0, 32'(o_rep[0]),   32'h1);
    chk("rpt5_valid", 1, 32'(o_valid[1]), 32'h0);
    fall();

    idle(12);
    rise(32'hFE01_1234);
    for (int i = 0; i < 2; i++) begin
      chk("late_valid", i, 32'(o_valid[i]), 32'h1);
      chk("late_rep",   i, 32'(o_rep[i]),   32'h0);
    end
    fall();

    // window edge: 10 cycles after handshake still a repeat, 11 is a fresh command
    idle(9);
    rise(32'hFE01_1234);
    chk("edge10_rep",   0, 32'(o_rep[0]),   32'h1);
    chk("edge10_valid", 1, 32'(o_valid[1]), 32'h0);
    fall();
    idle(10);
    rise(32'hFE01_1234);
    for (int i = 0; i < 2; i++) begin
      chk("edge11_valid", i, 32'(o_valid[i]), 32'h1);
      chk("edge11_rep",   i, 32'(o_rep[i]),   32'h0);
    end
    fall();

    idle(15);
    rise(32'hFE02_5555);
    for (int i = 0; i < 2; i++) begin
      chk("badfrm_valid", i, 32'(o_valid[i]), 32'h0);
      chk("badfrm_err",   i, 32'(o_err[i]),   32'h1);
    end
    fall();

    // overflow while the consumer stalls
    ready = 1'b0;
    idle(15);
    rise(32'hFE01_0000); fall();
    rise(32'hFD02_0000); fall();
    for (int i = 0; i < 2; i++) begin
      chk("ovf_cmd",  i, 32'(o_cmd[i]),   32'h01);
      chk("ovf_flag", i, 32'(o_ovf[i]),   32'h1);
      chk("ovf_vld",  i, 32'(o_valid[i]), 32'h1);
    end
    ready = 1'b1;
    idle(4);
    for (int i = 0; i < 2; i++) begin
      chk("ovf_drain_vld", i, 32'(o_valid[i]), 32'h0);
      chk("ovf_drain_cmd", i, 32'(o_cmd[i]),   32'h01);
    end

    idle(15);
    rise(32'hF30C_0000); fall();
    for (int i = 0; i < 2; i++) chk("mute_on", i, 32'(o_mute[i]), 32'h1);
    idle(12);
    rise(32'hF30C_0000); fall();
    for (int i = 0; i < 2; i++) chk("mute_off", i, 32'(o_mute[i]), 32'h0);

    // reset while a command is offered
    ready = 1'b0;
    idle(15);
    rise(32'hFE01_0000);
    for (int i = 0; i < 2; i++) chk("pre_rst_vld", i, 32'(o_valid[i]), 32'h1);
    rst_n = 1'b0;
    dr    = 1'b0;
    tick();
    lit_all_zero("mid_rst");

    // level already high at release is not a frame
    data = 32'hFE01_0000;
    dr   = 1'b1;
    tick();
    rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < 2; i++) chk("hi_release_vld", i, 32'(o_valid[i]), 32'h0);
    fall();
    ready = 1'b1;
    idle(2);

    repeat (300) begin
      rise(32'hFE02_0000);
      fall();
    end
    for (int i = 0; i < 2; i++) chk("err_sat", i, 32'(o_err[i]), 32'hFF);

    repeat (3000) begin
      rst_n = ($urandom_range(0, 299) != 0);
      ready = ($urandom_range(0, 9) < 7);
      dr    = 1'($urandom_range(0, 1));
      k     = keys[$urandom_range(0, 2)];
      if ($urandom_range(0, 99) < 85) data = {~k, k, 16'($urandom)};
      else                            data = $urandom;
      tick();
    end

    rst_n = 1'b1;
    dr    = 1'b0;
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
